// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction and writeback-source select.
// After reset a clear sequencer writes x1..x31 through the register-file write port.
module writeback_stage #(
  parameter logic [31:0] SP_INIT   = 32'h0000_0FFC,
  parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_Valid,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_Rd,
  input  logic [1:0]  MEM_WB_Sel,
  input  logic [2:0]  MEM_Funct3,
  input  logic [1:0]  MEM_Addr_Low,
  input  logic [31:0] MEM_ALU_Result,
  input  logic [31:0] MEM_Read_Data,
  input  logic [31:0] MEM_PC_Plus4,
  input  logic [31:0] MEM_Imm,
  output logic [4:0]  Write_Reg,
  output logic [31:0] Write_Data,
  output logic        RegWrite,
  output logic        Init_Busy,
  output logic        WB_Valid,
  output logic        Load_Fault,
  output logic [31:0] Retire_Count
);

  typedef enum logic {INIT, RUN} state_t;

  state_t      state;
  logic [4:0]  clear_cnt;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_low;
  logic [31:0] wb_alu;
  logic [31:0] wb_rdata;
  logic [31:0] wb_pc4;
  logic [31:0] wb_imm;
  logic [31:0] retire_cnt;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        load_bad;
  logic        fault;
  logic [31:0] run_data;

  // MEM_* is ignored while clearing; the WB register only starts capturing in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      clear_cnt   <= 5'd1;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_sel      <= '0;
      wb_funct3   <= '0;
      wb_addr_low <= '0;
      wb_alu      <= '0;
      wb_rdata    <= '0;
      wb_pc4      <= '0;
      wb_imm      <= '0;
      retire_cnt  <= '0;
    end else begin
      case (state)
        INIT: begin
          clear_cnt <= clear_cnt + 5'd1;
          if (clear_cnt == 5'd31)
            state <= RUN;
        end
        RUN: begin
          wb_valid    <= MEM_Valid;
          wb_regwrite <= MEM_RegWrite;
          wb_rd       <= MEM_Rd;
          wb_sel      <= MEM_WB_Sel;
          wb_funct3   <= MEM_Funct3;
          wb_addr_low <= MEM_Addr_Low;
          wb_alu      <= MEM_ALU_Result;
          wb_rdata    <= MEM_Read_Data;
          wb_pc4      <= MEM_PC_Plus4;
          wb_imm      <= MEM_Imm;
          if (wb_valid && !fault)
            retire_cnt <= retire_cnt + 32'd1;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    case (wb_addr_low)
      2'd0:    load_byte = wb_rdata[7:0];
      2'd1:    load_byte = wb_rdata[15:8];
      2'd2:    load_byte = wb_rdata[23:16];
      default: load_byte = wb_rdata[31:24];
    endcase
    load_half = wb_addr_low[1] ? wb_rdata[31:16] : wb_rdata[15:0];
    load_data = '0;
    load_bad  = 1'b0;
    case (wb_funct3)
      3'b000: load_data = {{24{load_byte[7]}}, load_byte};
      3'b001: begin
        load_data = {{16{load_half[15]}}, load_half};
        load_bad  = wb_addr_low[0];
      end
      3'b010: begin
        load_data = wb_rdata;
        load_bad  = (wb_addr_low != 2'd0);
      end
      3'b100: load_data = {24'd0, load_byte};
      3'b101: begin
        load_data = {16'd0, load_half};
        load_bad  = wb_addr_low[0];
      end
      default: begin
        load_data = '0;
        load_bad  = 1'b1;
      end
    endcase
  end

  assign fault = wb_valid && (wb_sel == 2'b01) && load_bad;

  always_comb begin
    case (wb_sel)
      2'b00:   run_data = wb_alu;
      2'b01:   run_data = load_data;
      2'b10:   run_data = wb_pc4;
      default: run_data = wb_imm;
    endcase
  end

  // Write port is held quiet while reset is asserted, even though the counter already sits at x1
  always_comb begin
    Write_Reg  = '0;
    Write_Data = '0;
    RegWrite   = 1'b0;
    if (reset) begin
      if (state == INIT) begin
        Write_Reg  = clear_cnt;
        Write_Data = (clear_cnt == 5'd2) ? SP_INIT : CLEAR_VAL;
        RegWrite   = 1'b1;
      end else begin
        Write_Reg  = wb_rd;
        Write_Data = run_data;
        RegWrite   = wb_valid && wb_regwrite && (wb_rd != 5'd0) && !fault;
      end
    end
  end

  assign Init_Busy    = (state == INIT);
  assign WB_Valid     = wb_valid;
  assign Load_Fault   = fault;
  assign Retire_Count = retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage against a plain-arithmetic model
// of the MEM/WB register, load extraction and retire counting.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_sel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr;
  logic [31:0] mem_alu;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc4;
  logic [31:0] mem_imm;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        init_busy;
  logic        wb_valid;
  logic        load_fault;
  logic [31:0] retire_count;

  int n_cmp = 0;
  int n_bad = 0;

  // expected contents of the instruction sitting in WB
  logic        exp_valid;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_fault;
  logic        exp_we;
  logic [31:0] exp_rc;

  writeback_stage dut (
    .clk(clk), .reset(reset),
    .MEM_Valid(mem_valid), .MEM_RegWrite(mem_regwrite), .MEM_Rd(mem_rd),
    .MEM_WB_Sel(mem_sel), .MEM_Funct3(mem_funct3), .MEM_Addr_Low(mem_addr),
    .MEM_ALU_Result(mem_alu), .MEM_Read_Data(mem_rdata), .MEM_PC_Plus4(mem_pc4),
    .MEM_Imm(mem_imm),
    .Write_Reg(write_reg), .Write_Data(write_data), .RegWrite(reg_write),
    .Init_Busy(init_busy), .WB_Valid(wb_valid), .Load_Fault(load_fault),
    .Retire_Count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void load_model(input int unsigned f3, input int unsigned addr,
                                     input int unsigned rdata,
                                     output logic [31:0] data, output logic bad);
    int unsigned b, h;
    b = (rdata >> (8 * addr)) % 256;
    h = (rdata >> (16 * (addr / 2))) % 65536;
    bad = 1'b0;
    case (f3)
      0: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: begin data = (h >= 32768) ? h + 32'hFFFF_0000 : h; bad = (addr % 2) != 0; end
      2: begin data = rdata; bad = (addr != 0); end
      4: data = b;
      5: begin data = h; bad = (addr % 2) != 0; end
      default: begin data = 0; bad = 1'b1; end
    endcase
  endfunction

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] addr,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input logic [31:0] imm);
    mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_sel = sel; mem_funct3 = f3;
    mem_addr = addr; mem_alu = alu; mem_rdata = rdata; mem_pc4 = pc4; mem_imm = imm;
  endtask

  // one RUN clock: the old WB instruction retires, the driven MEM fields become the new one
  task automatic advance();
    logic [31:0] ld;
    logic        bad;
    @(posedge clk); #1;
    if (exp_valid && !exp_fault) exp_rc = exp_rc + 1;
    load_model(mem_funct3, mem_addr, mem_rdata, ld, bad);
    exp_valid = mem_valid;
    exp_rd    = mem_rd;
    case (mem_sel)
      2'd0: exp_data = mem_alu;
      2'd1: exp_data = ld;
      2'd2: exp_data = mem_pc4;
      default: exp_data = mem_imm;
    endcase
    exp_fault = mem_valid && (mem_sel == 2'd1) && bad;
    exp_we    = mem_valid && mem_regwrite && (mem_rd != 0) && !exp_fault;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (write_reg !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_write_reg: got %0d expected 0", write_reg); end
    n_cmp++; if (write_data !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_write_data: got %h expected 0", write_data); end
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_regwrite: got %b expected 0", reg_write); end
    n_cmp++; if (init_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_init_busy: got %b expected 1", init_busy); end
    n_cmp++; if ({wb_valid, load_fault} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_valid_fault: got %b expected 00", {wb_valid, load_fault}); end
    n_cmp++; if (retire_count !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_retire: got %0d expected 0", retire_count); end
  endtask

  task automatic test_init();
    logic [31:0] want;
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, $urandom, $urandom, $urandom, $urandom);
    #1;
    for (int i = 1; i <= 31; i++) begin
      want = (i == 2) ? 32'h0000_0FFC : 32'h0;
      n_cmp++; if (write_reg !== i[4:0]) begin n_bad++; $display("[TB] FAIL init_reg: got %0d expected %0d", write_reg, i); end
      n_cmp++; if (write_data !== want) begin n_bad++; $display("[TB] FAIL init_data x%0d: got %h expected %h", i, write_data, want); end
      n_cmp++; if ({reg_write, init_busy, wb_valid} !== 3'b110) begin n_bad++; $display("[TB] FAIL init_flags x%0d: got %b expected 110", i, {reg_write, init_busy, wb_valid}); end
      mem_alu = $urandom;
      @(posedge clk); #1;
    end
    n_cmp++; if (init_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL init_done_busy: got %b expected 0", init_busy); end
    n_cmp++; if ({reg_write, wb_valid} !== 2'b00) begin n_bad++; $display("[TB] FAIL init_done_flags: got %b expected 00", {reg_write, wb_valid}); end
    exp_valid = 0; exp_fault = 0; exp_we = 0; exp_rc = 0;
  endtask

  task automatic test_lb();
    drive(1, 1, 5'd5, 2'd1, 3'b000, 2'd3, 0, 32'h80FF_1234, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (write_reg !== 5'd5) begin n_bad++; $display("[TB] FAIL lb_reg: got %0d expected 5", write_reg); end
    n_cmp++; if (write_data !== 32'hFFFF_FF80) begin n_bad++; $display("[TB] FAIL lb_data: got %h expected ffffff80", write_data); end
    n_cmp++; if ({reg_write, load_fault} !== 2'b10) begin n_bad++; $display("[TB] FAIL lb_flags: got %b expected 10", {reg_write, load_fault}); end
    advance();
    n_cmp++; if (retire_count !== exp_rc) begin n_bad++; $display("[TB] FAIL lb_retire: got %0d expected %0d", retire_count, exp_rc); end
  endtask

  task automatic test_lhu_lh();
    logic [31:0] rc0;
    drive(1, 1, 5'd6, 2'd1, 3'b101, 2'd2, 0, 32'h80FF_1234, 0, 0);
    advance();
    drive(1, 1, 5'd7, 2'd1, 3'b001, 2'd1, 0, 32'h80FF_1234, 0, 0);
    n_cmp++; if (write_data !== 32'h0000_80FF) begin n_bad++; $display("[TB] FAIL lhu_data: got %h expected 000080ff", write_data); end
    n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("[TB] FAIL lhu_we: got %b expected 1", reg_write); end
    advance();
    rc0 = retire_count;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if ({reg_write, load_fault} !== 2'b01) begin n_bad++; $display("[TB] FAIL lh_misaligned: got %b expected 01", {reg_write, load_fault}); end
    advance();
    n_cmp++; if (retire_count !== rc0) begin n_bad++; $display("[TB] FAIL lh_no_retire: got %0d expected %0d", retire_count, rc0); end
  endtask

  task automatic test_alu_jal();
    logic [31:0] rc0;
    rc0 = exp_rc;
    drive(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 0, 0);
    advance();
    drive(1, 1, 5'd1, 2'd2, 3'd0, 2'd0, 0, 0, 32'h0000_0104, 0);
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("[TB] FAIL alu_rd0_we: got %b expected 0", reg_write); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (retire_count !== rc0 + 32'd1) begin n_bad++; $display("[TB] FAIL alu_rd0_retire: got %0d expected %0d", retire_count, rc0 + 1); end
    n_cmp++; if (write_data !== 32'h0000_0104) begin n_bad++; $display("[TB] FAIL jal_data: got %h expected 00000104", write_data); end
    n_cmp++; if ({reg_write, write_reg} !== {1'b1, 5'd1}) begin n_bad++; $display("[TB] FAIL jal_we_reg: got %b/%0d expected 1/1", reg_write, write_reg); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0), $urandom_range(31, 0),
            $urandom_range(3, 0), $urandom_range(7, 0), $urandom_range(3, 0),
            $urandom, $urandom, $urandom, $urandom);
      advance();
      n_cmp++; if ({wb_valid, load_fault, reg_write} !== {exp_valid, exp_fault, exp_we}) begin
        n_bad++; $display("[TB] FAIL rand_flags #%0d: got %b expected %b", n, {wb_valid, load_fault, reg_write}, {exp_valid, exp_fault, exp_we});
      end
      n_cmp++; if (retire_count !== exp_rc) begin n_bad++; $display("[TB] FAIL rand_retire #%0d: got %0d expected %0d", n, retire_count, exp_rc); end
      if (exp_we) begin
        n_cmp++; if ({write_reg, write_data} !== {exp_rd, exp_data}) begin
          n_bad++; $display("[TB] FAIL rand_write #%0d: got x%0d=%h expected x%0d=%h", n, write_reg, write_data, exp_rd, exp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    n_cmp++; if (retire_count === 32'd0) begin n_bad++; $display("[TB] FAIL pre_reset_retire: got 0 expected nonzero"); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({reg_write, init_busy, wb_valid, load_fault} !== 4'b0100) begin n_bad++; $display("[TB] FAIL run_reset_flags: got %b expected 0100", {reg_write, init_busy, wb_valid, load_fault}); end
    n_cmp++; if ({write_reg, write_data, retire_count} !== 69'd0) begin n_bad++; $display("[TB] FAIL run_reset_values: got x%0d=%h rc=%0d expected zeros", write_reg, write_data, retire_count); end
    test_init();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive((i % 2) == 0, 1, 5'd3 + i[4:0], 2'd3, 3'd0, 2'd0, 0, 0, 0, 32'h1000 * (i + 1));
      advance();
      n_cmp++; if (reg_write !== ((i % 2) == 0)) begin n_bad++; $display("[TB] FAIL bubble_we #%0d: got %b expected %b", i, reg_write, (i % 2) == 0); end
    end
    n_cmp++; if (retire_count !== 32'd3) begin n_bad++; $display("[TB] FAIL bubble_retire: got %0d expected 3", retire_count); end
  endtask

  task automatic test_reset_mid_init();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    n_cmp++; if (write_reg !== 5'd10) begin n_bad++; $display("[TB] FAIL mid_init_reg: got %0d expected 10", write_reg); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({reg_write, write_reg, init_busy} !== {1'b0, 5'd0, 1'b1}) begin n_bad++; $display("[TB] FAIL init_reset_flags: got %b/%0d/%b expected 0/0/1", reg_write, write_reg, init_busy); end
    test_init();
  endtask

  initial begin
    exp_valid = 0; exp_fault = 0; exp_we = 0; exp_rc = 0; exp_rd = 0; exp_data = 0;
    test_reset();
    test_init();
    test_lb();
    test_lhu_lh();
    test_alu_jal();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Holds the MEM/WB pipeline register, extracts and extends load data, and selects the writeback source.
- Drives the register file's write port: Write_Reg, Write_Data, RegWrite.
- After reset, a clear sequencer writes initial values to x1..x31 through that same write port, so the register file needs no file-based initialisation.
- Init_Busy stalls the upstream pipeline until the clear is done.

Parameters:
- SP_INIT, 32'h0000_0FFC, value written to x2 (sp) during the clear sequence.
- CLEAR_VAL, 32'h0000_0000, value written to every other register x1, x3..x31.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- MEM_Valid  in  1  MEM stage holds a real instruction.
- MEM_RegWrite  in  1  instruction writes rd.
- MEM_Rd  in  5  destination register.
- MEM_WB_Sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- MEM_Funct3  in  3  load width/sign code.
- MEM_Addr_Low  in  2  byte offset of the load address.
- MEM_ALU_Result  in  32  ALU result.
- MEM_Read_Data  in  32  raw word from data memory.
- MEM_PC_Plus4  in  32  link value.
- MEM_Imm  in  32  U-type immediate.
- Write_Reg  out  5  to register file.
- Write_Data  out  32  to register file; also the forwarding value.
- RegWrite  out  1  to register file.
- Init_Busy  out  1  clear sequence active; upstream must stall.
- WB_Valid  out  1  WB register holds a valid instruction.
- Load_Fault  out  1  current WB load is misaligned or has an illegal funct3.
- Retire_Count  out  32  count of retired, non-faulted instructions.

Behaviour:
- Reset (reset=0, async):
  - FSM enters INIT; clear counter = 1.
  - WB register cleared; WB_Valid = 0; Retire_Count = 0; Load_Fault = 0.
  - Write_Reg = 0, Write_Data = 0, RegWrite = 0, Init_Busy = 1.
- FSM states: INIT, RUN.
- INIT, one register per cycle, starting on the first cycle after reset deassertion:
  - Write_Reg = counter, RegWrite = 1.
  - Write_Data = SP_INIT when counter == 2, else CLEAR_VAL.
  - Counter increments on each rising edge.
  - After the cycle that writes x31, go to RUN. That is 31 write cycles total.
  - Init_Busy = 1 throughout INIT. All MEM_* inputs are ignored and WB_Valid stays 0.
- RUN:
  - Init_Busy = 0.
  - On each rising edge, the WB register captures all MEM_* fields, and WB_Valid <= MEM_Valid.
  - Latency is one cycle from MEM to register-file write.
- Outputs in RUN are combinational from the WB register only and stable for the whole cycle:
  - Write_Reg = WB_Rd.
  - Write_Data is selected by WB_Sel: ALU result, extracted load, PC+4, or immediate.
  - RegWrite = WB_Valid & WB_RegWrite & (WB_Rd != 0) & ~Load_Fault.
- Load extraction (WB_Sel = 01); byte lane = Addr_Low, half lane = Addr_Low[1]:
  - 000 LB: byte, sign-extended.
  - 001 LH: half, sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - 011, 110, 111: illegal. Load_Fault = 1, Write_Data = 0.
- Misalignment (raises Load_Fault, RegWrite = 0):
  - LH/LHU with Addr_Low[0] = 1.
  - LW with Addr_Low != 0.
- Load_Fault is 0 whenever WB_Sel != 01 or WB_Valid = 0.
- Retire_Count:
  - Increments on each rising edge where WB_Valid = 1 and Load_Fault = 0.
  - Includes instructions with rd = 0 or RegWrite = 0 (stores, branches).
  - Wraps modulo 2^32.
- Bubble: MEM_Valid = 0 gives WB_Valid = 0 the next cycle and RegWrite = 0. Write_Reg and Write_Data still follow the captured fields and are don't-care.
- rd = 0 is never written, regardless of source.
- Reset during INIT or RUN aborts immediately and restarts INIT at x1. There is no partial-state carryover.

Test Plan:
- Release reset, hold MEM_Valid = 1 → 31 consecutive cycles with RegWrite = 1 and Write_Reg = 1..31. Write_Data = 0x00000FFC at x2 and 0 elsewhere. Init_Busy drops on cycle 32; WB_Valid stays 0 throughout.
- RUN, LB: Addr_Low = 3, Read_Data = 0x80FF1234, rd = 5 → next cycle Write_Reg = 5, Write_Data = 0xFFFFFF80, RegWrite = 1, Retire_Count +1.
- RUN, LHU: Addr_Low = 2, Read_Data = 0x80FF1234 → Write_Data = 0x000080FF. Then LH with Addr_Low = 1 → RegWrite = 0, Load_Fault = 1, Retire_Count unchanged.
- RUN, ALU op: rd = 0, ALU = 0xDEADBEEF → RegWrite = 0, Retire_Count +1. Then JAL: rd = 1, WB_Sel = 10, PC+4 = 0x104 → Write_Data = 0x104, RegWrite = 1.
- Alternate MEM_Valid 1/0 over 6 cycles → RegWrite pulses only on the cycles after valid inputs; Retire_Count ends at 3.
- Assert reset while the INIT counter = 10 (and again mid-RUN) → outputs clear immediately. On release, the sequence restarts at Write_Reg = 1 and Retire_Count = 0.
